// File: rtl/if_id_pipe_reg_if.sv
// rtl/if_id_pipe_reg_if.sv - IF/ID pipeline register bus interface
//
// Purpose: bundles the IF-side capture inputs, the ID-side registered
//          outputs and the optional performance counters into one bus.
// Signals:
//   flush_i           IF -> reg   load a bubble at the next edge
//   IF_ID_write_en_i  IF -> reg   0 = stall (hold contents)
//   IF_instruction_i  IF -> reg   fetched instruction
//   IF_pc_i           IF -> reg   PC of fetched instruction
//   IF_pc_plus4_i     IF -> reg   PC+4 of fetched instruction
//   ID_instruction_o  reg -> ID   registered instruction
//   ID_pc_o           reg -> ID   registered PC
//   ID_pc_plus4_o     reg -> ID   registered PC+4
//   ID_valid_o        reg -> ID   1 = real instruction, 0 = bubble/reset
//   stall_cnt_o       reg -> ID   stall edge count (IF_ID_PERF_CNT_EN only)
//   flush_cnt_o       reg -> ID   flush edge count (IF_ID_PERF_CNT_EN only)
// Modports: master = pipeline side driving IF inputs, slave = the register.
// Optional macro: IF_ID_PERF_CNT_EN

interface if_id_pipe_reg_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush_i;
    logic                  IF_ID_write_en_i;
    logic [DATA_WIDTH-1:0] IF_instruction_i;
    logic [DATA_WIDTH-1:0] IF_pc_i;
    logic [DATA_WIDTH-1:0] IF_pc_plus4_i;
    logic [DATA_WIDTH-1:0] ID_instruction_o;
    logic [DATA_WIDTH-1:0] ID_pc_o;
    logic [DATA_WIDTH-1:0] ID_pc_plus4_o;
    logic                  ID_valid_o;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0]           stall_cnt_o;
    logic [31:0]           flush_cnt_o;
`endif

    modport master (
        output flush_i, IF_ID_write_en_i, IF_instruction_i, IF_pc_i, IF_pc_plus4_i,
        input  ID_instruction_o, ID_pc_o, ID_pc_plus4_o, ID_valid_o
`ifdef IF_ID_PERF_CNT_EN
        , input stall_cnt_o, flush_cnt_o
`endif
    );

    modport slave (
        input  flush_i, IF_ID_write_en_i, IF_instruction_i, IF_pc_i, IF_pc_plus4_i,
        output ID_instruction_o, ID_pc_o, ID_pc_plus4_o, ID_valid_o
`ifdef IF_ID_PERF_CNT_EN
        , output stall_cnt_o, flush_cnt_o
`endif
    );
endinterface

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF/ID pipeline register with stall and flush
//
// Purpose: captures instruction, PC and PC+4 from IF and presents them to
//          ID one cycle later. Every output comes straight from a flop.
// Ports:
//   clk   in   single clock, rising-edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of if_id_pipe_reg_if (capture inputs, ID outputs,
//         optional performance counters)
// Parameters:
//   DATA_WIDTH  width of instruction, PC and PC+4 fields
//   NOP_INSTR   bubble instruction loaded on reset or flush
// Optional macro: IF_ID_PERF_CNT_EN adds stall_cnt_o / flush_cnt_o.

module if_id_pipe_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = {DATA_WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    if_id_pipe_reg_if.slave   bus
);
    logic [DATA_WIDTH-1:0] r_instruction;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pc_plus4;
    logic                  r_valid;

    // Priority: reset, then flush (which overrides a stall), then capture,
    // otherwise hold everything including valid.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            r_instruction <= NOP_INSTR;
            r_pc          <= '0;
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
        end else if (bus.IF_ID_write_en_i) begin
            r_instruction <= bus.IF_instruction_i;
            r_pc          <= bus.IF_pc_i;
            r_pc_plus4    <= bus.IF_pc_plus4_i;
            r_valid       <= 1'b1;
        end
    end

    assign bus.ID_instruction_o = r_instruction;
    assign bus.ID_pc_o          = r_pc;
    assign bus.ID_pc_plus4_o    = r_pc_plus4;
    assign bus.ID_valid_o       = r_valid;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Observation only; counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.flush_i) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
        end else if (!bus.IF_ID_write_en_i) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;
`endif
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - self-checking bench for if_id_pipe_reg

module tb_if_id_pipe_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Reference state derived from the update rules
    logic [31:0] exp_instr, exp_pc, exp_pc4;
    logic        exp_valid;
    logic [31:0] exp_stall, exp_flush;

    if_id_pipe_reg_if #(.DATA_WIDTH(32)) bus ();

    if_id_pipe_reg #(.DATA_WIDTH(32), .NOP_INSTR(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Apply one edge of stimulus and advance the reference model.
    task automatic step(input logic r, input logic f, input logic we,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] pc4);
        @(negedge clk);
        rst = r;
        bus.flush_i = f;
        bus.IF_ID_write_en_i = we;
        bus.IF_instruction_i = ins;
        bus.IF_pc_i = pc;
        bus.IF_pc_plus4_i = pc4;
        @(posedge clk);
        if (r) begin
            {exp_instr, exp_pc, exp_pc4, exp_valid} = {96'd0, 1'b0};
            exp_stall = 0;
            exp_flush = 0;
        end else if (f) begin
            {exp_instr, exp_pc, exp_pc4, exp_valid} = {96'd0, 1'b0};
            exp_flush = exp_flush + 1;
        end else if (we) begin
            {exp_instr, exp_pc, exp_pc4, exp_valid} = {ins, pc, pc4, 1'b1};
        end else begin
            exp_stall = exp_stall + 1;
        end
        #1;
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        total++; if (bus.ID_instruction_o !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=%h", bus.ID_instruction_o, 32'h0); end
        total++; if (bus.ID_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", bus.ID_pc_o, 32'h0); end
        total++; if (bus.ID_pc_plus4_o !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h want=%h", bus.ID_pc_plus4_o, 32'h0); end
        total++; if (bus.ID_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.ID_valid_o); end
    endtask

    task automatic test_capture;
        step(0, 0, 1, 32'hABCDEF01, 32'h00001000, 32'h00001004);
        total++; if (bus.ID_instruction_o !== 32'hABCDEF01) begin bad++; $display("FAIL cap_instr got=%h want=ABCDEF01", bus.ID_instruction_o); end
        total++; if (bus.ID_pc_o !== 32'h00001000) begin bad++; $display("FAIL cap_pc got=%h want=00001000", bus.ID_pc_o); end
        total++; if (bus.ID_pc_plus4_o !== 32'h00001004) begin bad++; $display("FAIL cap_pc4 got=%h want=00001004", bus.ID_pc_plus4_o); end
        total++; if (bus.ID_valid_o !== 1'b1) begin bad++; $display("FAIL cap_valid got=%b want=1", bus.ID_valid_o); end
    endtask

    task automatic test_stall;
        step(0, 0, 0, 32'hFFFFFFFF, 32'h00002000, 32'h00002004);
        total++; if (bus.ID_instruction_o !== 32'hABCDEF01) begin bad++; $display("FAIL stall_instr got=%h want=ABCDEF01", bus.ID_instruction_o); end
        total++; if (bus.ID_pc_o !== 32'h00001000) begin bad++; $display("FAIL stall_pc got=%h want=00001000", bus.ID_pc_o); end
        total++; if (bus.ID_pc_plus4_o !== 32'h00001004) begin bad++; $display("FAIL stall_pc4 got=%h want=00001004", bus.ID_pc_plus4_o); end
        total++; if (bus.ID_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", bus.ID_valid_o); end
    endtask

    task automatic test_flush;
        step(0, 1, 1, 32'h12345678, 32'h00003000, 32'h00003004);
        total++; if ({bus.ID_instruction_o, bus.ID_pc_o, bus.ID_pc_plus4_o, bus.ID_valid_o} !== 97'd0) begin bad++; $display("FAIL flush_we1 got=%h/%h/%h/%b want=0/0/0/0", bus.ID_instruction_o, bus.ID_pc_o, bus.ID_pc_plus4_o, bus.ID_valid_o); end
        // Reload real content so the stalled flush has something to clear
        step(0, 0, 1, 32'h12345678, 32'h00003000, 32'h00003004);
        total++; if (bus.ID_valid_o !== 1'b1) begin bad++; $display("FAIL flush_reload_valid got=%b want=1", bus.ID_valid_o); end
        step(0, 1, 0, 32'h12345678, 32'h00003000, 32'h00003004);
        total++; if ({bus.ID_instruction_o, bus.ID_pc_o, bus.ID_pc_plus4_o, bus.ID_valid_o} !== 97'd0) begin bad++; $display("FAIL flush_we0 got=%h/%h/%h/%b want=0/0/0/0", bus.ID_instruction_o, bus.ID_pc_o, bus.ID_pc_plus4_o, bus.ID_valid_o); end
    endtask

    task automatic test_resume;
        step(0, 0, 1, 32'hAABBCCDD, 32'h00004000, 32'h00004004);
        total++; if (bus.ID_instruction_o !== 32'hAABBCCDD) begin bad++; $display("FAIL resume_instr got=%h want=AABBCCDD", bus.ID_instruction_o); end
        total++; if (bus.ID_pc_o !== 32'h00004000) begin bad++; $display("FAIL resume_pc got=%h want=00004000", bus.ID_pc_o); end
        total++; if (bus.ID_pc_plus4_o !== 32'h00004004) begin bad++; $display("FAIL resume_pc4 got=%h want=00004004", bus.ID_pc_plus4_o); end
        total++; if (bus.ID_valid_o !== 1'b1) begin bad++; $display("FAIL resume_valid got=%b want=1", bus.ID_valid_o); end
    endtask

    task automatic test_random;
        logic [31:0] pc;
        for (int i = 0; i < 300; i++) begin
            pc = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(0, 31) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0, $urandom(), pc, pc + 32'd4);
            total++;
            if ({bus.ID_instruction_o, bus.ID_pc_o, bus.ID_pc_plus4_o, bus.ID_valid_o} !==
                {exp_instr, exp_pc, exp_pc4, exp_valid}) begin
                bad++;
                $display("FAIL rand_%0d got=%h/%h/%h/%b want=%h/%h/%h/%b", i,
                         bus.ID_instruction_o, bus.ID_pc_o, bus.ID_pc_plus4_o, bus.ID_valid_o,
                         exp_instr, exp_pc, exp_pc4, exp_valid);
            end
`ifdef IF_ID_PERF_CNT_EN
            total++;
            if ({bus.stall_cnt_o, bus.flush_cnt_o} !== {exp_stall, exp_flush}) begin
                bad++;
                $display("FAIL rand_cnt_%0d got=%0d/%0d want=%0d/%0d", i,
                         bus.stall_cnt_o, bus.flush_cnt_o, exp_stall, exp_flush);
            end
`endif
        end
    endtask

`ifdef IF_ID_PERF_CNT_EN
    task automatic test_perf;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h1, 32'h2, 32'h6);
        for (int i = 0; i < 2; i++) step(0, 1, $urandom_range(0, 1), 32'h1, 32'h2, 32'h6);
        total++; if (bus.stall_cnt_o !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d want=3", bus.stall_cnt_o); end
        total++; if (bus.flush_cnt_o !== 32'd2) begin bad++; $display("FAIL perf_flush got=%0d want=2", bus.flush_cnt_o); end
        step(1, 1, 0, 0, 0, 0);
        total++; if (bus.stall_cnt_o !== 32'd0) begin bad++; $display("FAIL perf_stall_rst got=%0d want=0", bus.stall_cnt_o); end
        total++; if (bus.flush_cnt_o !== 32'd0) begin bad++; $display("FAIL perf_flush_rst got=%0d want=0", bus.flush_cnt_o); end
    endtask
`endif

    initial begin
        bus.flush_i = 1'b0;
        bus.IF_ID_write_en_i = 1'b0;
        bus.IF_instruction_i = '0;
        bus.IF_pc_i = '0;
        bus.IF_pc_plus4_i = '0;
        exp_stall = 0;
        exp_flush = 0;
        test_reset();
        test_capture();
        test_stall();
        test_flush();
        test_resume();
`ifdef IF_ID_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
